// File: rtl/pkt_sim_pkg.sv
// Shared types and constants for the pkt-sim edge port sink.
//   parser_state_t   : packet parser states (header, size, payload)
//   COUNTER_WIDTH    : width of every statistics counter
//   addr_field_width : width of the destination address field in a header flit
package pkt_sim_pkg;

    localparam int COUNTER_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_HEADER  = 2'd0,
        ST_SIZE    = 2'd1,
        ST_PAYLOAD = 2'd2
    } parser_state_t;

    // The destination address lives in the lower half of the header flit.
    function automatic int addr_field_width(input int flit_width);
        return flit_width / 2;
    endfunction

endpackage

// File: rtl/edge_port_sink_fifo.sv
// flit_fifo: small synchronous FIFO buffering flits between the port
// handshake and the packet parser.
//   clock, reset   : clock, synchronous active-high reset (empties the FIFO)
//   push_i, data_i : write request and flit
//   pop_i, data_o  : read request and head flit (combinational read)
//   full_o, empty_o: occupancy flags for the current cycle
//   count_o        : current occupancy
//   count_next_o   : occupancy after this cycle's push/pop
module flit_fifo
    import pkt_sim_pkg::*;
#(
    parameter int FLIT_WIDTH   = 16,
    parameter int BUFFER_DEPTH = 4,
    localparam int PTR_W       = $clog2(BUFFER_DEPTH),
    localparam int CNT_W       = PTR_W + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic [FLIT_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [FLIT_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [CNT_W-1:0]      count_o,
    output logic [CNT_W-1:0]      count_next_o
);

    logic [FLIT_WIDTH-1:0] mem_q [BUFFER_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(BUFFER_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is allowed only when the head leaves the
    // same cycle, so occupancy stays at depth.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        count_next_o = count_q;
        case ({do_push, do_pop})
            2'b10:   count_next_o = count_q + CNT_W'(1);
            2'b01:   count_next_o = count_q - CNT_W'(1);
            default: count_next_o = count_q;
        endcase
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_next_o;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/edge_port_sink.sv
// edge_port_sink: receive-side endpoint terminating an open mesh port.
// Accepts flits under credit flow control, buffers them in flit_fifo,
// parses packets (header, size, payload) and keeps statistics.
//   clock, reset      : single clock, synchronous active-high reset
//   clock_rx          : forwarded port clock, unused (single-clock design)
//   rx, data_i        : flit valid and flit from the router
//   credit_o          : registered space-available to the router
//   stall_i           : holds the FIFO head, no flit drained while high
//   pkt_done_o        : one-cycle pulse after a packet's last flit is consumed
//   last_header_o/last_size_o : header and size of the latest completed packet
//   pkt_count_o, flit_count_o, misroute_count_o, overrun_count_o : counters
module edge_port_sink
    import pkt_sim_pkg::*;
#(
    parameter int                    FLIT_WIDTH   = 16,
    parameter logic [FLIT_WIDTH-1:0] ADDRESS      = '0,
    parameter int                    BUFFER_DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clock_rx,
    input  logic                     rx,
    input  logic [FLIT_WIDTH-1:0]    data_i,
    output logic                     credit_o,
    input  logic                     stall_i,
    output logic                     pkt_done_o,
    output logic [FLIT_WIDTH-1:0]    last_header_o,
    output logic [FLIT_WIDTH-1:0]    last_size_o,
    output logic [COUNTER_WIDTH-1:0] pkt_count_o,
    output logic [COUNTER_WIDTH-1:0] flit_count_o,
    output logic [COUNTER_WIDTH-1:0] misroute_count_o,
    output logic [COUNTER_WIDTH-1:0] overrun_count_o
);

    localparam int                AW         = addr_field_width(FLIT_WIDTH);
    localparam int                CNT_W      = $clog2(BUFFER_DEPTH) + 1;
    localparam logic [AW-1:0]     ADDR_FIELD = ADDRESS[AW-1:0];

    logic unused_clock_rx;
    assign unused_clock_rx = clock_rx;

    // ---------------- handshake and buffering ----------------
    logic                  credit_q;
    logic                  accept, pop;
    logic [FLIT_WIDTH-1:0] flit;
    logic                  fifo_full, fifo_empty;
    logic [CNT_W-1:0]      fifo_count, fifo_count_next;

    assign accept = rx && credit_q;
    assign pop    = !stall_i && !fifo_empty;

    flit_fifo #(
        .FLIT_WIDTH  (FLIT_WIDTH),
        .BUFFER_DEPTH(BUFFER_DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (accept),
        .data_i      (data_i),
        .pop_i       (pop),
        .data_o      (flit),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .count_next_o(fifo_count_next)
    );

    logic unused_fifo;
    assign unused_fifo = fifo_full ^ (^fifo_count);

    // ---------------- parser ----------------
    parser_state_t         state_q, state_d;
    logic [FLIT_WIDTH-1:0] header_q, header_d;
    logic [FLIT_WIDTH-1:0] size_q, size_d;
    logic [FLIT_WIDTH-1:0] remaining_q, remaining_d;
    logic                  done_d;

    always_comb begin
        state_d     = state_q;
        header_d    = header_q;
        size_d      = size_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        if (pop) begin
            case (state_q)
                ST_HEADER: begin
                    header_d = flit;
                    state_d  = ST_SIZE;
                end
                ST_SIZE: begin
                    size_d      = flit;
                    remaining_d = flit;
                    if (flit == '0) begin
                        done_d  = 1'b1;
                        state_d = ST_HEADER;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    remaining_d = remaining_q - FLIT_WIDTH'(1);
                    if (remaining_q == FLIT_WIDTH'(1)) begin
                        done_d  = 1'b1;
                        state_d = ST_HEADER;
                    end
                end
                default: state_d = ST_HEADER;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_HEADER;
            header_q    <= '0;
            size_q      <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            header_q    <= header_d;
            size_q      <= size_d;
            remaining_q <= remaining_d;
        end
    end

    // ---------------- outputs and statistics ----------------
    logic                     pkt_done_q;
    logic [FLIT_WIDTH-1:0]    last_header_q, last_size_q;
    logic [COUNTER_WIDTH-1:0] pkt_count_q, flit_count_q, misroute_count_q, overrun_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            credit_q         <= 1'b0;
            pkt_done_q       <= 1'b0;
            last_header_q    <= '0;
            last_size_q      <= '0;
            pkt_count_q      <= '0;
            flit_count_q     <= '0;
            misroute_count_q <= '0;
            overrun_count_q  <= '0;
        end else begin
            // Credit reflects occupancy after this cycle, so a sender that
            // honours it never finds the FIFO full.
            credit_q   <= (fifo_count_next != CNT_W'(BUFFER_DEPTH));
            pkt_done_q <= done_d;
            if (accept)
                flit_count_q <= flit_count_q + COUNTER_WIDTH'(1);
            if (rx && !credit_q)
                overrun_count_q <= overrun_count_q + COUNTER_WIDTH'(1);
            if (done_d) begin
                // header_d/size_d already hold this packet's fields, including
                // the zero-size case where the size flit is popped this cycle.
                last_header_q <= header_d;
                last_size_q   <= size_d;
                pkt_count_q   <= pkt_count_q + COUNTER_WIDTH'(1);
                if (header_d[AW-1:0] != ADDR_FIELD)
                    misroute_count_q <= misroute_count_q + COUNTER_WIDTH'(1);
            end
        end
    end

    assign credit_o         = credit_q;
    assign pkt_done_o       = pkt_done_q;
    assign last_header_o    = last_header_q;
    assign last_size_o      = last_size_q;
    assign pkt_count_o      = pkt_count_q;
    assign flit_count_o     = flit_count_q;
    assign misroute_count_o = misroute_count_q;
    assign overrun_count_o  = overrun_count_q;

endmodule

// File: tb/tb_edge_port_sink.sv
module tb_edge_port_sink;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clock_rx = 1'b0;
    logic        rx = 1'b0;
    logic [15:0] data = '0;
    logic        stall = 1'b0;
    logic        credit_o, pkt_done_o;
    logic [15:0] last_header_o, last_size_o;
    logic [31:0] pkt_count_o, flit_count_o, misroute_count_o, overrun_count_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] hdr;
        logic [15:0] size;
        logic [31:0] pkts;
        logic [31:0] mis;
    } exp_t;
    exp_t sb[$];

    always #5 clock = ~clock;

    edge_port_sink #(
        .FLIT_WIDTH  (16),
        .ADDRESS     (16'h0011),
        .BUFFER_DEPTH(4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .clock_rx        (clock_rx),
        .rx              (rx),
        .data_i          (data),
        .credit_o        (credit_o),
        .stall_i         (stall),
        .pkt_done_o      (pkt_done_o),
        .last_header_o   (last_header_o),
        .last_size_o     (last_size_o),
        .pkt_count_o     (pkt_count_o),
        .flit_count_o    (flit_count_o),
        .misroute_count_o(misroute_count_o),
        .overrun_count_o (overrun_count_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every pkt_done pulse must match the oldest expectation.
    always @(negedge clock) begin
        if (pkt_done_o) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pkt_done: hdr %h with empty scoreboard", last_header_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_header", {16'h0, last_header_o}, {16'h0, e.hdr});
                chk("sb_size", {16'h0, last_size_o}, {16'h0, e.size});
                chk("sb_pkt_count", pkt_count_o, e.pkts);
                chk("sb_misroute", misroute_count_o, e.mis);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Credit-honouring send; a credit that never arrives counts as a failure.
    task automatic send_flit(input logic [15:0] d);
        int n = 0;
        while (!credit_o && n < 200) begin
            step(1);
            n++;
        end
        if (!credit_o) begin
            total++;
            bad++;
            $display("FAIL credit_timeout: credit %b expected 1", credit_o);
            return;
        end
        rx = 1'b1;
        data = d;
        step(1);
        rx = 1'b0;
    endtask

    task automatic push_exp(input logic [15:0] h, input logic [15:0] s,
                            input logic [31:0] p, input logic [31:0] m);
        exp_t e;
        e.hdr = h; e.size = s; e.pkts = p; e.mis = m;
        sb.push_back(e);
    endtask

    bit s3_done = 1'b0;

    initial begin
        // ---- reset state ----
        step(2);
        chk("rst_credit", {31'h0, credit_o}, 32'd0);
        chk("rst_pkt_done", {31'h0, pkt_done_o}, 32'd0);
        chk("rst_pkt_count", pkt_count_o, 32'd0);
        chk("rst_last_header", {16'h0, last_header_o}, 32'd0);
        reset = 1'b0;
        step(1);
        chk("credit_after_reset", {31'h0, credit_o}, 32'd1);

        // ---- 1: good packet, 3 payload flits back-to-back ----
        push_exp(16'h0011, 16'd3, 32'd1, 32'd0);
        send_flit(16'h0011);
        send_flit(16'd3);
        send_flit(16'h000A);
        send_flit(16'h000B);
        send_flit(16'h000C);
        step(4);
        chk("t1_flit_count", flit_count_o, 32'd5);
        chk("t1_pkt_count", pkt_count_o, 32'd1);
        chk("t1_last_size", {16'h0, last_size_o}, 32'd3);

        // ---- 2: zero-size misrouted packet, latency of pkt_done ----
        push_exp(16'h0022, 16'd0, 32'd2, 32'd1);
        send_flit(16'h0022);
        send_flit(16'd0);
        @(negedge clock);
        chk("t2_done_not_early", {31'h0, pkt_done_o}, 32'd0);
        @(negedge clock);
        chk("t2_done_pulse", {31'h0, pkt_done_o}, 32'd1);
        @(negedge clock);
        chk("t2_done_one_cycle", {31'h0, pkt_done_o}, 32'd0);
        chk("t2_misroute", misroute_count_o, 32'd1);
        chk("t2_last_header", {16'h0, last_header_o}, 32'h0022);
        step(1);

        // ---- 3: stall with credit-honouring sender, 10-payload packet ----
        stall = 1'b1;
        push_exp(16'h0011, 16'd10, 32'd3, 32'd1);
        fork
            begin
                send_flit(16'h0011);
                send_flit(16'd10);
                for (int i = 0; i < 10; i++) send_flit(16'(16'h0A00 + i));
                s3_done = 1'b1;
            end
        join_none
        step(10);
        chk("t3_stalled_flits", flit_count_o, 32'd11);
        chk("t3_credit_low", {31'h0, credit_o}, 32'd0);
        stall = 1'b0;
        begin
            int g = 0;
            while (!s3_done && g < 300) begin step(1); g++; end
        end
        chk("t3_sender_done", {31'h0, s3_done}, 32'd1);
        step(6);
        chk("t3_flit_count", flit_count_o, 32'd19);
        chk("t3_overrun", overrun_count_o, 32'd0);

        // ---- 4: overrun against a full FIFO ----
        stall = 1'b1;
        push_exp(16'h0011, 16'd2, 32'd4, 32'd1);
        send_flit(16'h0011);
        send_flit(16'd2);
        send_flit(16'h0B01);
        send_flit(16'h0B02);
        chk("t4_full_credit", {31'h0, credit_o}, 32'd0);
        rx = 1'b1;
        data = 16'hDEAD;
        step(3);
        rx = 1'b0;
        chk("t4_overrun", overrun_count_o, 32'd3);
        chk("t4_flit_count", flit_count_o, 32'd23);
        stall = 1'b0;
        step(6);
        chk("t4_pkt_count", pkt_count_o, 32'd4);

        // ---- 5: reset mid-packet, rx during reset ignored ----
        send_flit(16'h0011);
        send_flit(16'd5);
        send_flit(16'h0C01);
        step(2);
        reset = 1'b1;
        rx = 1'b1;
        data = 16'h0055;
        step(1);
        rx = 1'b0;
        chk("t5_rst_credit", {31'h0, credit_o}, 32'd0);
        chk("t5_rst_flits", flit_count_o, 32'd0);
        chk("t5_rst_overrun", overrun_count_o, 32'd0);
        chk("t5_rst_pkts", pkt_count_o, 32'd0);
        reset = 1'b0;
        step(1);
        chk("t5_credit_back", {31'h0, credit_o}, 32'd1);
        // Upper header half is not part of the address check.
        push_exp(16'h0111, 16'd1, 32'd1, 32'd0);
        send_flit(16'h0111);
        send_flit(16'd1);
        send_flit(16'h0C02);
        step(4);
        chk("t5_flit_count", flit_count_o, 32'd3);
        chk("t5_pkt_count", pkt_count_o, 32'd1);

        // ---- 6: flit counter wrap ----
        force dut.flit_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.flit_count_q;
        chk("t6_preload", flit_count_o, 32'hFFFF_FFFF);
        push_exp(16'h0011, 16'd0, 32'd2, 32'd0);
        send_flit(16'h0011);
        chk("t6_wrap0", flit_count_o, 32'd0);
        send_flit(16'd0);
        chk("t6_wrap1", flit_count_o, 32'd1);
        step(5);

        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/edge_port_sink.md
# edge_port_sink

Receive-side endpoint for one router mesh port (S/N/W/E) left open at the mesh boundary in pkt-sim. Plays the receiver role of the router port handshake: accepts flits under credit flow control, buffers them, parses packets (header, size, payload) and keeps delivery and error counters. Lets benches terminate edge ports and check that traffic leaving a PE's `pe_if` is well-formed and correctly addressed.

## Interface
Parameters:
- `FLIT_WIDTH`, 16: flit width in bits; must be even.
- `ADDRESS`, 0: expected destination address of arriving packets (lower `FLIT_WIDTH/2` bits).
- `BUFFER_DEPTH`, 4: input FIFO depth in flits; power of two, ≥2.

Ports:
- `clock`  in  1: single clock; all logic on rising edge.
- `reset`  in  1: synchronous, active-high.
- `clock_rx`  in  1: port forwarded clock; ignored (single-clock design).
- `rx`  in  1: flit valid from the router's `tx`.
- `data_i`  in  FLIT_WIDTH: flit from the router's `data_o`.
- `credit_o`  out  1: space available; drives the router's `credit_i`.
- `stall_i`  in  1: bench backpressure; while high, no flit is drained from the FIFO.
- `pkt_done_o`  out  1: one-cycle pulse when the last flit of a packet is consumed.
- `last_header_o`  out  FLIT_WIDTH: header flit of the most recent completed packet.
- `last_size_o`  out  FLIT_WIDTH: size flit of the most recent completed packet.
- `pkt_count_o`  out  32: completed packets.
- `flit_count_o`  out  32: flits accepted into the FIFO.
- `misroute_count_o`  out  32: completed packets whose header address ≠ `ADDRESS`.
- `overrun_count_o`  out  32: cycles with `rx`=1 while `credit_o`=0.

## Operation
- Accept: flit written into FIFO iff `rx && credit_o`; `flit_count_o` += 1.
- Overrun: `rx && !credit_o` → flit dropped, `overrun_count_o` += 1, FIFO and FSM unchanged.
- `credit_o` = registered `!full_next`, where `full_next` is FIFO occupancy after this cycle's push/pop equals `BUFFER_DEPTH`. A sender honouring credit never overruns.
- Drain: when `!stall_i` and FIFO non-empty, pop one flit per cycle into the parser.
- Simultaneous push and pop on a full FIFO: both happen, occupancy unchanged, `credit_o` stays 0.
- Parser FSM (states in package):
  - `ST_HEADER`: popped flit → header register; go `ST_SIZE`.
  - `ST_SIZE`: popped flit → size register, remaining counter = flit value; if 0 → packet complete, go `ST_HEADER`; else go `ST_PAYLOAD`.
  - `ST_PAYLOAD`: each pop decrements remaining; pop at remaining=1 completes the packet, go `ST_HEADER`.
- Packet complete (same edge as final pop): `pkt_done_o`=1 next cycle, `last_header_o`/`last_size_o` updated, `pkt_count_o` += 1; if `header[FLIT_WIDTH/2-1:0] != ADDRESS[FLIT_WIDTH/2-1:0]` then `misroute_count_o` += 1. Upper header half is not checked.
- All counters are 32-bit and wrap modulo 2^32; no saturation.
- Size field is unsigned, full `FLIT_WIDTH`; maximum payload 2^FLIT_WIDTH−1 flits.

## Timing
- Reset (synchronous): FIFO emptied, FSM → `ST_HEADER`, all counters 0, `last_header_o`=0, `last_size_o`=0, `pkt_done_o`=0, `credit_o`=0.
- First cycle after `reset` deasserts: `credit_o`=1.
- Reset mid-packet discards the partial packet and buffered flits; no counter update, no `pkt_done_o`.
- Latency: flit accepted at edge N is poppable at edge N+1 (FIFO empty, `stall_i`=0). The final flit accepted at edge N gives `pkt_done_o` high in cycle N+1→N+2.
- `rx` arriving during reset is ignored, and is not counted as an overrun.
- Throughput: 1 flit/cycle sustained with `stall_i`=0.

## Structure
- `pkt_sim_pkg`: `parser_state_t` enum (`ST_HEADER`, `ST_SIZE`, `ST_PAYLOAD`), `COUNTER_WIDTH`=32, header address field split (`FLIT_WIDTH/2`).
- Sub-module `flit_fifo` (parameters `FLIT_WIDTH`, `BUFFER_DEPTH`; push/pop/full/empty/occupancy). Parser and counters stay in `edge_port_sink`.

## Test plan
- Reset, `ADDRESS`=8'h11; send header 16'h0011, size 3, payload A,B,C back-to-back → `pkt_done_o` pulse once, `pkt_count_o`=1, `flit_count_o`=5, `last_size_o`=3, `misroute_count_o`=0.
- Header 16'h0022, size 0 → packet completes after 2 flits, `misroute_count_o`=1, `last_header_o`=16'h0022.
- `stall_i`=1 with a credit-honouring sender, 10-flit packet, `BUFFER_DEPTH`=4 → exactly 4 flits accepted, `credit_o`=0; release stall → all 12 flits delivered, `overrun_count_o`=0.
- With FIFO full, force `rx`=1 for 3 cycles ignoring credit → `overrun_count_o`=3, `flit_count_o` unchanged.
- Assert `reset` after header+size+1 payload of a 5-payload packet → counters 0, `credit_o`=0 then 1; the next full packet parses correctly (`pkt_count_o`=1).
- Preload `flit_count_o` near 2^32−1 (force), send 2 flits → wraps to 0 and then 1.
